up_dn_cmd_ctrl: RTL and testbench

Front-end command stage that drives the up/down counter from three raw pushbuttons and a 5-bit switch bank. For each button it synchronizes, debounces and edge-detects the input, and adds auto-repeat on the Up and Down buttons. It then applies command priority and saturation suppression, and issues single-cycle Load/Up/Down pulses plus the IN load value. It sits directly upstream of the counter and also consumes the counter's High/Low flags.

---
 rtl/up_dn_cmd_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/up_dn_cmd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_up_dn_cmd_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/up_dn_cmd_pkg.sv
// Shared types and timing constants for the up/down counter command front end.
// Includes a short-timing constant set so simulations finish quickly.
package up_dn_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    REPEAT,
    WAIT_REL
  } btn_state_e;

  localparam int DEF_DEB_CYCLES   = 50000;
  localparam int DEF_REPEAT_DELAY = 500000;
  localparam int DEF_REPEAT_RATE  = 100000;
  localparam int DEF_DATA_W       = 5;

  localparam int SIM_DEB_CYCLES   = 4;
  localparam int SIM_REPEAT_DELAY = 8;
  localparam int SIM_REPEAT_RATE  = 4;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one raw button.
// The debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
module btn_debounce
  import up_dn_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic deb_o
);

  localparam int CW = cnt_w(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Turns raw Up/Down/Load buttons and a switch bank into single-cycle counter commands,
// with auto-repeat on Up/Down, Load priority and High/Low saturation suppression.
module up_dn_cmd_ctrl
  import up_dn_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Btn_Up,
  input  logic              Btn_Down,
  input  logic              Btn_Load,
  input  logic [DATA_W-1:0] Sw_In,
  input  logic              High,
  input  logic              Low,
  output logic [DATA_W-1:0] IN,
  output logic              Load,
  output logic              Up,
  output logic              Down
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = cnt_w(REP_MAX);

  logic deb_up, deb_dn, deb_ld;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk_i (CLK),
    .rst_i (RST),
    .btn_i (Btn_Up),
    .deb_o (deb_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk_i (CLK),
    .rst_i (RST),
    .btn_i (Btn_Down),
    .deb_o (deb_dn)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ld (
    .clk_i (CLK),
    .rst_i (RST),
    .btn_i (Btn_Load),
    .deb_o (deb_ld)
  );

  // Switches are sampled only on Load, so a plain synchronizer is enough.
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;

  // Index 0 = Up button, index 1 = Down button.
  logic [1:0]  rep_deb, rep_prev_q, rep_rise, rep_req;
  btn_state_e  rep_state_q [2];
  btn_state_e  rep_state_d [2];
  logic [RW-1:0] rep_cnt_q [2];
  logic [RW-1:0] rep_cnt_d [2];

  logic       ld_prev_q, ld_rise, ld_req;
  btn_state_e ld_state_q, ld_state_d;

  logic [DATA_W-1:0] in_q, in_d;
  logic              load_q, load_d, up_q, up_d, down_q, down_d;

  assign rep_deb  = {deb_dn, deb_up};
  assign rep_rise = rep_deb & ~rep_prev_q;
  assign ld_rise  = deb_ld & ~ld_prev_q;

  // Requests are qualified by the live debounced level so a release that lands
  // on a repeat slot never leaks a pulse.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      rep_state_d[b] = rep_state_q[b];
      rep_cnt_d[b]   = rep_cnt_q[b];
      rep_req[b]     = 1'b0;
      case (rep_state_q[b])
        IDLE: begin
          if (rep_rise[b]) begin
            rep_state_d[b] = PRESS;
            rep_cnt_d[b]   = '0;
          end
        end
        PRESS: begin
          rep_req[b]     = rep_deb[b];
          rep_state_d[b] = HOLD;
          rep_cnt_d[b]   = '0;
        end
        HOLD: begin
          if (rep_cnt_q[b] == RW'(REPEAT_DELAY - 1)) begin
            rep_state_d[b] = REPEAT;
            rep_cnt_d[b]   = '0;
          end else begin
            rep_cnt_d[b] = rep_cnt_q[b] + RW'(1);
          end
        end
        REPEAT: begin
          rep_req[b] = rep_deb[b] && (rep_cnt_q[b] == '0);
          if (rep_cnt_q[b] == RW'(REPEAT_RATE - 1)) begin
            rep_cnt_d[b] = '0;
          end else begin
            rep_cnt_d[b] = rep_cnt_q[b] + RW'(1);
          end
        end
        default: begin
          rep_state_d[b] = IDLE;
          rep_cnt_d[b]   = '0;
        end
      endcase
      if ((rep_state_q[b] != IDLE) && !rep_deb[b]) begin
        rep_state_d[b] = IDLE;
        rep_cnt_d[b]   = '0;
      end
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    ld_req     = 1'b0;
    case (ld_state_q)
      IDLE:     if (ld_rise) ld_state_d = PRESS;
      PRESS: begin
        ld_req     = deb_ld;
        ld_state_d = WAIT_REL;
      end
      WAIT_REL: if (!deb_ld) ld_state_d = IDLE;
      default:  ld_state_d = IDLE;
    endcase
    if ((ld_state_q != IDLE) && !deb_ld) ld_state_d = IDLE;
  end

  // Load beats everything; a blocked Down is dropped rather than handed to Up.
  always_comb begin
    in_d   = in_q;
    load_d = 1'b0;
    up_d   = 1'b0;
    down_d = 1'b0;
    if (ld_req) begin
      load_d = 1'b1;
      in_d   = sw_s2_q;
    end else if (rep_req[1]) begin
      down_d = !Low;
    end else if (rep_req[0]) begin
      up_d = !High;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      rep_prev_q <= '0;
      ld_prev_q  <= 1'b0;
      ld_state_q <= IDLE;
      for (int b = 0; b < 2; b++) begin
        rep_state_q[b] <= IDLE;
        rep_cnt_q[b]   <= '0;
      end
      in_q   <= '0;
      load_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      sw_s1_q    <= Sw_In;
      sw_s2_q    <= sw_s1_q;
      rep_prev_q <= rep_deb;
      ld_prev_q  <= deb_ld;
      ld_state_q <= ld_state_d;
      for (int b = 0; b < 2; b++) begin
        rep_state_q[b] <= rep_state_d[b];
        rep_cnt_q[b]   <= rep_cnt_d[b];
      end
      in_q   <= in_d;
      load_q <= load_d;
      up_q   <= up_d;
      down_q <= down_d;
    end
  end

  assign IN   = in_q;
  assign Load = load_q;
  assign Up   = up_q;
  assign Down = down_q;

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Directed bench for up_dn_cmd_ctrl at short timing (DEB=4, DELAY=8, RATE=4).
// Step i of a case samples 1 ns after the i-th clock edge following stimulus set-up.
module tb_up_dn_cmd_ctrl;
  import up_dn_cmd_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Btn_Up = 1'b0, Btn_Down = 1'b0, Btn_Load = 1'b0;
  logic [4:0] Sw_In = '0;
  logic       High = 1'b0, Low = 1'b0;
  logic [4:0] IN;
  logic       Load, Up, Down;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  up_dn_cmd_ctrl #(
    .DEB_CYCLES   (SIM_DEB_CYCLES),
    .REPEAT_DELAY (SIM_REPEAT_DELAY),
    .REPEAT_RATE  (SIM_REPEAT_RATE),
    .DATA_W       (5)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Btn_Up   (Btn_Up),
    .Btn_Down (Btn_Down),
    .Btn_Load (Btn_Load),
    .Sw_In    (Sw_In),
    .High     (High),
    .Low      (Low),
    .IN       (IN),
    .Load     (Load),
    .Up       (Up),
    .Down     (Down)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int n);
    Btn_Up = 1'b0; Btn_Down = 1'b0; Btn_Load = 1'b0;
    High = 1'b0; Low = 1'b0; RST = 1'b0;
    repeat (n) step();
  endtask

  // Buttons in btn = {load, up, down} are held for steps 1..hold; High/Low forced
  // for steps 1..sat_until; RST pulsed on step rst_at (0 = never).
  task automatic run_case(input string tag, input logic [2:0] btn, input int hold,
                          input int nsteps, input int sat_until, input logic hi,
                          input logic lo, input int rst_at, input logic [63:0] exp_ld,
                          input logic [63:0] exp_up, input logic [63:0] exp_dn);
    for (int i = 1; i <= nsteps; i++) begin
      Btn_Load = btn[2] && (i <= hold);
      Btn_Up   = btn[1] && (i <= hold);
      Btn_Down = btn[0] && (i <= hold);
      High     = hi && (i <= sat_until);
      Low      = lo && (i <= sat_until);
      RST      = (i == rst_at);
      step();
      check_val($sformatf("%s.load@%0d", tag, i), 32'(Load), 32'(exp_ld[i]));
      check_val($sformatf("%s.up@%0d", tag, i), 32'(Up), 32'(exp_up[i]));
      check_val($sformatf("%s.down@%0d", tag, i), 32'(Down), 32'(exp_dn[i]));
    end
    drain(20);
  endtask

  localparam logic [63:0] P8 = 64'd1 << 8;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every button held: outputs stay quiet, then Load wins 7 edges later.
    RST = 1'b1; Btn_Up = 1'b1; Btn_Down = 1'b1; Btn_Load = 1'b1; Sw_In = 5'd9;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_val($sformatf("rst.load@%0d", i), 32'(Load), 0);
      check_val($sformatf("rst.up@%0d", i), 32'(Up), 0);
      check_val($sformatf("rst.down@%0d", i), 32'(Down), 0);
      check_val($sformatf("rst.in@%0d", i), 32'(IN), 0);
    end
    RST = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (i == 9) begin
        Btn_Up = 1'b0; Btn_Down = 1'b0; Btn_Load = 1'b0;
      end
      step();
      check_val($sformatf("post_rst.load@%0d", i), 32'(Load), (i == 8) ? 1 : 0);
      check_val($sformatf("post_rst.up@%0d", i), 32'(Up), 0);
      check_val($sformatf("post_rst.down@%0d", i), 32'(Down), 0);
      check_val($sformatf("post_rst.in@%0d", i), 32'(IN), (i >= 8) ? 9 : 0);
    end
    drain(10);

    // Bouncing Up: level never stable for 4 samples, so nothing fires.
    for (int i = 1; i <= 40; i++) begin
      Btn_Up = (i <= 20) && (((i - 1) / 2) % 2 == 0);
      step();
      check_val($sformatf("bounce.up@%0d", i), 32'(Up), 0);
    end
    drain(10);

    run_case("clean_up", 3'b010, 5, 30, 0, 1'b0, 1'b0, 0, 64'd0, P8, 64'd0);

    run_case("repeat_dn", 3'b001, 40, 60, 0, 1'b0, 1'b0, 0, 64'd0, 64'd0,
             P8 | (64'd1 << 17) | (64'd1 << 21) | (64'd1 << 25) | (64'd1 << 29) |
             (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 41) | (64'd1 << 45));

    // Load priority: all three pressed together; IN then holds while Sw_In moves.
    Sw_In = 5'd28;
    drain(5);
    run_case("ld_prio", 3'b111, 8, 30, 0, 1'b0, 1'b0, 0, P8, 64'd0, 64'd0);
    check_val("ld_prio.in", 32'(IN), 28);
    Sw_In = 5'd3;
    drain(10);
    check_val("ld_hold.in", 32'(IN), 28);

    run_case("sat_high", 3'b010, 30, 50, 22, 1'b1, 1'b0, 0, 64'd0,
             (64'd1 << 25) | (64'd1 << 29) | (64'd1 << 33), 64'd0);
    run_case("sat_low", 3'b001, 30, 50, 22, 1'b0, 1'b1, 0, 64'd0, 64'd0,
             (64'd1 << 25) | (64'd1 << 29) | (64'd1 << 33));

    run_case("both", 3'b011, 8, 25, 0, 1'b0, 1'b0, 0, 64'd0, 64'd0, P8);
    run_case("both_low", 3'b011, 20, 35, 35, 1'b0, 1'b1, 0, 64'd0, 64'd0, 64'd0);

    // Reset mid-repeat: slot 21 is killed, held button re-detected 7 edges after reset.
    run_case("rst_mid", 3'b001, 30, 32, 0, 1'b0, 1'b0, 21, 64'd0, 64'd0,
             P8 | (64'd1 << 17) | (64'd1 << 29));
    check_val("rst_mid.in", 32'(IN), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
